dc_blocker_mc: RTL and testbench

- Parametrised, multi-channel successor to the single-channel audio DC blocker.
- Implements y(n) = x(n) − x(n−1) + y(n−1) − (y(n−1) >>> K_SHIFT) per channel.
- One shared arithmetic unit is time-multiplexed across channels, with guard bits, output saturation, bypass, and overrun/clip flags.
- Sits between the audio input front end (ADC/decimator) and downstream filtering; fires once per audio_trigger frame.

---
 rtl/dc_blocker_pkg.sv | 27 ++
 rtl/dc_blocker_alu.sv | 38 +++
 rtl/dc_blocker_mc.sv | 141 ++++++++++++++
 tb/tb_dc_blocker_mc.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_blocker_pkg.sv
// Shared types and helpers for the multi-channel DC blocker.
// Holds the frame FSM state encoding and the saturation helper.
package dc_blocker_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    PROC,
    COMMIT
  } state_t;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/dc_blocker_alu.sv
// One DC-blocker step: y = x - x_prev + y_prev - (y_prev >>> K_SHIFT), saturated.
// Combinational, zero latency, no flow control; bypass only suppresses the clip flag.
module dc_blocker_alu
  import dc_blocker_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int GUARD   = 2,
  parameter int K_SHIFT = 6
) (
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] x_prev,
  input  logic signed [WIDTH-1:0] y_prev,
  input  logic                    bypass,
  output logic signed [WIDTH-1:0] y_sat,
  output logic                    clip
);

  localparam int IW = WIDTH + GUARD;

  logic signed [IW-1:0] x_e;
  logic signed [IW-1:0] xp_e;
  logic signed [IW-1:0] yp_e;
  logic signed [IW-1:0] sum;
  logic signed [63:0]   sum_w;
  logic signed [63:0]   sat_w;

  always_comb begin
    x_e   = IW'(x);
    xp_e  = IW'(x_prev);
    yp_e  = IW'(y_prev);
    sum   = x_e - xp_e + yp_e - (yp_e >>> K_SHIFT);
    sum_w = 64'(sum);
    sat_w = sat_to_width(sum_w, WIDTH);
    y_sat = WIDTH'(sat_w);
    clip  = ~bypass & (sat_w != sum_w);
  end

endmodule

// File: rtl/dc_blocker_mc.sv
// Multi-channel DC blocker sharing one ALU across channels, one channel per cycle.
// Latency CHANNELS+1 from trigger to valid_out; triggers arriving mid-frame are dropped and flagged.
module dc_blocker_mc
  import dc_blocker_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int CHANNELS = 4,
  parameter int K_SHIFT  = 6,
  parameter int GUARD    = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      audio_trigger,
  input  logic [CHANNELS*WIDTH-1:0] signal_in,
  input  logic                      bypass_in,
  output logic [CHANNELS*WIDTH-1:0] signal_out,
  output logic                      valid_out,
  output logic                      busy_out,
  output logic                      clip_out,
  output logic                      overrun_out
);

  localparam int             CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CW-1:0]  LAST_CH = CW'(CHANNELS - 1);

  state_t                    state_q, state_d;
  logic [CW-1:0]             ch_q, ch_d;
  logic signed [WIDTH-1:0]   frame_q [CHANNELS];
  logic signed [WIDTH-1:0]   frame_d [CHANNELS];
  logic signed [WIDTH-1:0]   x_prev_q [CHANNELS];
  logic signed [WIDTH-1:0]   x_prev_d [CHANNELS];
  logic signed [WIDTH-1:0]   y_prev_q [CHANNELS];
  logic signed [WIDTH-1:0]   y_prev_d [CHANNELS];
  logic signed [WIDTH-1:0]   stage_q [CHANNELS];
  logic signed [WIDTH-1:0]   stage_d [CHANNELS];
  logic                      byp_q, byp_d;
  logic                      clip_acc_q, clip_acc_d;
  logic [CHANNELS*WIDTH-1:0] out_q, out_d;
  logic                      valid_q, valid_d;
  logic                      clip_q, clip_d;
  logic                      overrun_q, overrun_d;
  logic                      take;
  logic signed [WIDTH-1:0]   alu_y;
  logic                      alu_clip;

  dc_blocker_alu #(
    .WIDTH  (WIDTH),
    .GUARD  (GUARD),
    .K_SHIFT(K_SHIFT)
  ) u_alu (
    .x      (frame_q[ch_q]),
    .x_prev (x_prev_q[ch_q]),
    .y_prev (y_prev_q[ch_q]),
    .bypass (byp_q),
    .y_sat  (alu_y),
    .clip   (alu_clip)
  );

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    frame_d    = frame_q;
    x_prev_d   = x_prev_q;
    y_prev_d   = y_prev_q;
    stage_d    = stage_q;
    byp_d      = byp_q;
    clip_acc_d = clip_acc_q;
    out_d      = out_q;
    valid_d    = 1'b0;
    clip_d     = 1'b0;
    overrun_d  = overrun_q;
    take       = 1'b0;

    case (state_q)
      IDLE: take = audio_trigger;
      PROC: begin
        // Filter state advances even in bypass so leaving bypass resumes cleanly.
        x_prev_d[ch_q] = frame_q[ch_q];
        y_prev_d[ch_q] = alu_y;
        stage_d[ch_q]  = byp_q ? frame_q[ch_q] : alu_y;
        clip_acc_d     = clip_acc_q | alu_clip;
        if (audio_trigger) overrun_d = 1'b1;
        if (ch_q == LAST_CH) state_d = COMMIT;
        else                 ch_d    = ch_q + 1'b1;
      end
      COMMIT: begin
        for (int c = 0; c < CHANNELS; c++) out_d[c*WIDTH +: WIDTH] = stage_q[c];
        valid_d = 1'b1;
        clip_d  = clip_acc_q;
        state_d = IDLE;
        take    = audio_trigger;
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      for (int c = 0; c < CHANNELS; c++) frame_d[c] = signal_in[c*WIDTH +: WIDTH];
      byp_d      = bypass_in;
      ch_d       = '0;
      clip_acc_d = 1'b0;
      state_d    = PROC;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      frame_q    <= '{default: '0};
      x_prev_q   <= '{default: '0};
      y_prev_q   <= '{default: '0};
      stage_q    <= '{default: '0};
      byp_q      <= 1'b0;
      clip_acc_q <= 1'b0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      clip_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      frame_q    <= frame_d;
      x_prev_q   <= x_prev_d;
      y_prev_q   <= y_prev_d;
      stage_q    <= stage_d;
      byp_q      <= byp_d;
      clip_acc_q <= clip_acc_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      clip_q     <= clip_d;
      overrun_q  <= overrun_d;
    end
  end

  assign signal_out  = out_q;
  assign valid_out   = valid_q;
  assign busy_out    = (state_q != IDLE) && !valid_q;
  assign clip_out    = clip_q;
  assign overrun_out = overrun_q;

endmodule

// File: tb/tb_dc_blocker_mc.sv
// Bench for dc_blocker_mc: frame-level reference model plus literal pins on known sequences.
module tb_dc_blocker_mc;

  localparam int W  = 16;
  localparam int C  = 4;
  localparam int K  = 6;
  localparam int G  = 2;
  localparam int HI = (1 <<< (W - 1)) - 1;
  localparam int LO = -(1 <<< (W - 1));

  logic           clk = 1'b0;
  logic           rst;
  logic           trig;
  logic           byp;
  logic [C*W-1:0] sig;
  logic [C*W-1:0] signal_out;
  logic           valid_out;
  logic           busy_out;
  logic           clip_out;
  logic           overrun_out;

  always #5 clk = ~clk;

  dc_blocker_mc #(
    .WIDTH   (W),
    .CHANNELS(C),
    .K_SHIFT (K),
    .GUARD   (G)
  ) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .audio_trigger(trig),
    .signal_in    (sig),
    .bypass_in    (byp),
    .signal_out   (signal_out),
    .valid_out    (valid_out),
    .busy_out     (busy_out),
    .clip_out     (clip_out),
    .overrun_out  (overrun_out)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: whole frames are computed at the accepting edge and
  // released at accept + C + 1.
  typedef struct packed {
    int             due;
    logic [C*W-1:0] vals;
    logic           clip;
  } frame_t;

  frame_t         pend[$];
  int             xp[C];
  int             yp[C];
  int             edge_n   = 0;
  int             last_acc = 0;
  bit             have_acc = 1'b0;
  logic [C*W-1:0] m_out    = '0;
  bit             m_valid  = 1'b0;
  bit             m_clip   = 1'b0;
  bit             m_over   = 1'b0;
  bit             m_busy   = 1'b0;

  task automatic model_accept();
    frame_t f;
    f.due  = edge_n + C + 1;
    f.clip = 1'b0;
    f.vals = '0;
    for (int c = 0; c < C; c++) begin
      logic signed [W-1:0] xs;
      int x;
      int s;
      int y;
      xs = sig[c*W +: W];
      x  = int'(xs);
      s  = x - xp[c] + yp[c] - (yp[c] >>> K);
      y  = (s > HI) ? HI : ((s < LO) ? LO : s);
      if (y != s && !byp) f.clip = 1'b1;
      xp[c] = x;
      yp[c] = y;
      f.vals[c*W +: W] = byp ? xs : W'(y);
    end
    pend.push_back(f);
    last_acc = edge_n;
    have_acc = 1'b1;
  endtask

  task automatic model_edge();
    edge_n++;
    if (rst) begin
      for (int c = 0; c < C; c++) begin
        xp[c] = 0;
        yp[c] = 0;
      end
      pend.delete();
      have_acc = 1'b0;
      m_out    = '0;
      m_valid  = 1'b0;
      m_clip   = 1'b0;
      m_over   = 1'b0;
      m_busy   = 1'b0;
    end else begin
      m_valid = 1'b0;
      m_clip  = 1'b0;
      if (pend.size() > 0 && pend[0].due == edge_n) begin
        m_out   = pend[0].vals;
        m_clip  = pend[0].clip;
        m_valid = 1'b1;
        void'(pend.pop_front());
      end
      if (trig) begin
        if (!have_acc || edge_n >= last_acc + C + 1) model_accept();
        else m_over = 1'b1;
      end
      m_busy = (pend.size() > 0) && !m_valid;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s edge %0d: got %0h expected %0h", nm, edge_n, act, exp);
    end
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s edge %0d: got %0d expected %0d", nm, edge_n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("signal_out", 64'(signal_out), 64'(m_out));
    chk("valid_out", 64'(valid_out), 64'(m_valid));
    chk("busy_out", 64'(busy_out), 64'(m_busy));
    chk("clip_out", 64'(clip_out), 64'(m_clip));
    chk("overrun_out", 64'(overrun_out), 64'(m_over));
  endtask

  function automatic int chv(input int c);
    logic signed [W-1:0] v;
    v = signal_out[c*W +: W];
    return int'(v);
  endfunction

  function automatic logic [C*W-1:0] pk(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  function automatic logic [W-1:0] rsamp();
    case ($urandom_range(0, 3))
      0:       return W'(HI);
      1:       return W'(LO);
      default: return W'($urandom);
    endcase
  endfunction

  function automatic logic [C*W-1:0] rframe();
    logic [C*W-1:0] v;
    for (int c = 0; c < C; c++) v[c*W +: W] = rsamp();
    return v;
  endfunction

  task automatic frame(input logic [C*W-1:0] s, input bit b, input int gap);
    sig  = s;
    byp  = b;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    repeat (gap - 1) tick();
  endtask

  initial begin
    rst  = 1'b1;
    trig = 1'b0;
    byp  = 1'b0;
    sig  = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    lit("reset_ch0", chv(0), 0);
    lit("reset_busy", int'(busy_out), 0);

    // Step / negative step / saturation on separate channels; valid on edge T+5.
    frame(pk(1000, -1000, -32768, 0), 1'b0, 6);
    lit("f1_valid", int'(valid_out), 1);
    lit("f1_ch0", chv(0), 1000);
    lit("f1_ch1", chv(1), -1000);
    lit("f1_ch2", chv(2), -32768);
    lit("f1_clip", int'(clip_out), 0);
    frame(pk(1000, -1000, 32767, 0), 1'b0, 6);
    lit("f2_ch0", chv(0), 985);
    lit("f2_ch1", chv(1), -984);
    lit("f2_ch2", chv(2), 32767);
    lit("f2_clip", int'(clip_out), 1);
    frame(pk(1000, -1000, 32767, 0), 1'b0, 6);
    lit("f3_ch0", chv(0), 970);
    lit("f3_ch2", chv(2), 32256);
    lit("f3_clip", int'(clip_out), 0);
    lit("f3_ch3", chv(3), 0);

    // Trigger two cycles into a frame is dropped.
    sig  = rframe();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    repeat (6) tick();
    lit("overrun_set", int'(overrun_out), 1);
    frame(rframe(), 1'b0, 6);
    lit("overrun_sticky", int'(overrun_out), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    lit("overrun_cleared", int'(overrun_out), 0);

    for (int i = 0; i < 6; i++) frame(rframe(), 1'b0, 5);
    repeat (2) tick();
    lit("b2b_no_overrun", int'(overrun_out), 0);

    frame(pk(123, -7, 0, 32767), 1'b1, 6);
    lit("byp_ch0", chv(0), 123);
    lit("byp_ch1", chv(1), -7);
    lit("byp_ch2", chv(2), 0);
    lit("byp_ch3", chv(3), 32767);
    lit("byp_clip", int'(clip_out), 0);

    // Reset while processing: frame is abandoned.
    sig  = rframe();
    byp  = 1'b0;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lit("midrst_valid", int'(valid_out), 0);
    lit("midrst_busy", int'(busy_out), 0);
    lit("midrst_ch3", chv(3), 0);
    repeat (6) tick();

    for (int i = 0; i < 4000; i++) begin
      rst  = ($urandom_range(0, 299) == 0);
      trig = ($urandom_range(0, 3) == 0);
      byp  = ($urandom_range(0, 7) == 0);
      sig  = rframe();
      tick();
    end
    rst  = 1'b0;
    trig = 1'b0;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
